// File: rtl/ld_pkg.sv
// Shared constants, state encoding and decode helpers for the RV32I load controller.
package ld_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StAddr,
        StMemReq,
        StMemWait,
        StWb,
        StErr
    } state_e;

    // Cause latched on the way into StErr, emitted as a pulse on the way out
    typedef enum logic [1:0] {
        ExcNone,
        ExcIllegal,
        ExcMisaligned,
        ExcBus
    } exc_e;

    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
        logic mis;
        mis = 1'b0;
        if ((f3 == F3_LH) || (f3 == F3_LHU)) begin
            mis = ea_lo[0];
        end else if (f3 == F3_LW) begin
            mis = (ea_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Selects the byte/half/word addressed by ea[1:0] from a read word and extends it.
module load_align_ext
    import ld_pkg::*;
(
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] wdata
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select and sign/zero extension
    always_comb begin
        shifted  = rdata >> {ea_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = ea_lo[1] ? rdata[31:16] : rdata[15:0];
        wdata    = rdata;
        case (funct3)
            F3_LB:   wdata = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  wdata = {24'h0, byte_sel};
            F3_LH:   wdata = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  wdata = {16'h0, half_sel};
            default: wdata = rdata;
        endcase
    end

endmodule

// File: rtl/load_inst_ctrl.sv
// Multi-cycle controller for RV32I loads: decode, address, memory read, writeback.
module load_inst_ctrl
    import ld_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst_word,
    output logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            done,
    output logic            exc_illegal,
    output logic            exc_misaligned,
    output logic            exc_bus,
    output logic            busy
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    state_e      state_q;
    exc_e        exc_q;
    logic [31:0] inst_q;
    logic [31:0] ea_q;
    logic [31:0] rdata_q;
    logic [31:0] rf_wdata_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q;
    logic        rf_we_q;
    logic        done_q;
    logic        exc_illegal_q;
    logic        exc_misaligned_q;
    logic        exc_bus_q;

    logic [2:0]  funct3;
    logic [31:0] imm_sext;
    logic [31:0] ea_sum;
    logic [31:0] align_wdata;

    assign funct3   = inst_q[14:12];
    assign imm_sext = {{20{inst_q[31]}}, inst_q[31:20]};
    assign ea_sum   = rs1_data + imm_sext;

    load_align_ext u_align (
        .ea_lo  (ea_q[1:0]),
        .funct3 (funct3),
        .rdata  (rdata_q),
        .wdata  (align_wdata)
    );

    // Controller FSM with capture registers and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            exc_q            <= ExcNone;
            inst_q           <= '0;
            ea_q             <= '0;
            rdata_q          <= '0;
            rf_wdata_q       <= '0;
            cnt_q            <= '0;
            mem_req_q        <= 1'b0;
            rf_we_q          <= 1'b0;
            done_q           <= 1'b0;
            exc_illegal_q    <= 1'b0;
            exc_misaligned_q <= 1'b0;
            exc_bus_q        <= 1'b0;
        end else begin
            rf_we_q          <= 1'b0;
            done_q           <= 1'b0;
            exc_illegal_q    <= 1'b0;
            exc_misaligned_q <= 1'b0;
            exc_bus_q        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (inst_valid) begin
                        inst_q  <= inst_word;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if ((inst_q[6:0] != OPC_LOAD) || !funct3_legal(funct3)) begin
                        exc_q   <= ExcIllegal;
                        state_q <= StErr;
                    end else begin
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    ea_q <= ea_sum;
                    if (addr_misaligned(funct3, ea_sum[1:0])) begin
                        exc_q   <= ExcMisaligned;
                        state_q <= StErr;
                    end else begin
                        mem_req_q <= 1'b1;
                        state_q   <= StMemReq;
                    end
                end
                StMemReq: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (mem_rvalid) begin
                            rdata_q <= mem_rdata;
                            state_q <= StWb;
                        end else begin
                            state_q <= StMemWait;
                        end
                    end
                end
                StMemWait: begin
                    // rvalid takes priority over an expiring timeout
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        cnt_q   <= '0;
                        state_q <= StWb;
                    end else if (cnt_q == TimeoutLast) begin
                        cnt_q   <= '0;
                        exc_q   <= ExcBus;
                        state_q <= StErr;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StWb: begin
                    rf_we_q    <= (inst_q[11:7] != 5'd0);
                    rf_wdata_q <= align_wdata;
                    done_q     <= 1'b1;
                    state_q    <= StIdle;
                end
                StErr: begin
                    done_q           <= 1'b1;
                    exc_illegal_q    <= (exc_q == ExcIllegal);
                    exc_misaligned_q <= (exc_q == ExcMisaligned);
                    exc_bus_q        <= (exc_q == ExcBus);
                    exc_q            <= ExcNone;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign inst_ready     = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign rs1_addr       = inst_q[19:15];
    assign rf_waddr       = inst_q[11:7];
    assign mem_req        = mem_req_q;
    assign mem_addr       = {ea_q[31:2], 2'b00};
    assign rf_we          = rf_we_q;
    assign rf_wdata       = rf_wdata_q;
    assign done           = done_q;
    assign exc_illegal    = exc_illegal_q;
    assign exc_misaligned = exc_misaligned_q;
    assign exc_bus        = exc_bus_q;

endmodule
